// File: rtl/step1_ctrl.sv
// rtl/step1_ctrl.sv - sequencing controller: filter load, dot-product run, result hold
module step1_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cfg_len,
    input  logic [7:0] cfg_nvec,
    input  logic       load_start,
    input  logic       run_start,
    input  logic       filter_valid,
    output logic       filter_ready,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       filters_loaded,
    output logic       busy,
    output logic       r_w1,
    output logic [3:0] RF_EN,
    output logic [3:0] RF1_address,
    output logic       new_val,
    output logic       clear1,
    output logic       Dot_HOLD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t     state;
    logic [3:0] len;
    logic [3:0] eidx;
    logic [1:0] fidx;
    logic [7:0] vcnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            len            <= 4'd0;
            eidx           <= 4'd0;
            fidx           <= 2'd0;
            vcnt           <= 8'd0;
            filters_loaded <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state          <= S_LOAD;
                        filters_loaded <= 1'b0;
                        len            <= cfg_len;
                        fidx           <= 2'd0;
                        eidx           <= 4'd0;
                    end else if (run_start && filters_loaded && (cfg_nvec != 8'd0)) begin
                        state <= S_CLR;
                        len   <= cfg_len;
                        vcnt  <= cfg_nvec;
                    end
                end
                S_LOAD: begin
                    if (filter_valid) begin
                        if (eidx == len) begin
                            eidx <= 4'd0;
                            fidx <= fidx + 2'd1;
                            if (fidx == 2'd3) begin
                                state          <= S_IDLE;
                                filters_loaded <= 1'b1;
                            end
                        end else begin
                            eidx <= eidx + 4'd1;
                        end
                    end
                end
                S_CLR: begin
                    eidx  <= 4'd0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (data_valid) begin
                        if (eidx == len) begin
                            eidx  <= 4'd0;
                            state <= S_FLUSH;
                        end else begin
                            eidx <= eidx + 4'd1;
                        end
                    end
                end
                S_FLUSH: state <= S_DONE;
                S_DONE: begin
                    if (result_ready) begin
                        vcnt  <= vcnt - 8'd1;
                        state <= (vcnt == 8'd1) ? S_IDLE : S_CLR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Only RF_EN, new_val and Dot_HOLD look at the valid inputs; the rest is pure state decode.
    logic in_load;
    logic in_run;
    assign in_load      = (state == S_LOAD);
    assign in_run       = (state == S_RUN);

    assign busy         = (state != S_IDLE);
    assign filter_ready = in_load;
    assign data_ready   = in_run;
    assign result_valid = (state == S_DONE);
    assign clear1       = (state == S_CLR);
    assign r_w1         = in_load;
    assign RF1_address  = (in_load || in_run) ? eidx : 4'd0;
    assign RF_EN        = (in_load && filter_valid) ? (4'b0001 << fidx) :
                          in_run                    ? 4'b1111 : 4'b0000;
    assign new_val      = in_run && data_valid;
    assign Dot_HOLD     = !(clear1 || (in_run && data_valid));

endmodule

// File: tb/tb_step1_ctrl.sv
// tb/tb_step1_ctrl.sv - self-checking bench for step1_ctrl with a behavioural step1 datapath
module tb_step1_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_nvec;
    logic        load_start, run_start;
    logic        filter_valid, filter_ready;
    logic        data_valid, data_ready;
    logic        result_valid, result_ready;
    logic        filters_loaded, busy, r_w1;
    logic [3:0]  RF_EN, RF1_address;
    logic        new_val, clear1, Dot_HOLD;
    logic [15:0] vector_data, input_data;

    always #5 clock = ~clock;

    step1_ctrl dut (
        .clock(clock), .reset(reset), .cfg_len(cfg_len), .cfg_nvec(cfg_nvec),
        .load_start(load_start), .run_start(run_start),
        .filter_valid(filter_valid), .filter_ready(filter_ready),
        .data_valid(data_valid), .data_ready(data_ready),
        .result_valid(result_valid), .result_ready(result_ready),
        .filters_loaded(filters_loaded), .busy(busy), .r_w1(r_w1),
        .RF_EN(RF_EN), .RF1_address(RF1_address),
        .new_val(new_val), .clear1(clear1), .Dot_HOLD(Dot_HOLD)
    );

    // behavioural step1: four register files and four accumulators
    logic [15:0]  rf [4][16];
    logic [31:0]  acc [4];
    logic [127:0] z;
    assign z = {acc[3], acc[2], acc[1], acc[0]};

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (r_w1 && RF_EN[i]) rf[i][RF1_address] <= vector_data;
            if (clear1) acc[i] <= 32'd0;
            else if (new_val && !Dot_HOLD)
                acc[i] <= acc[i] + 32'(rf[i][RF1_address]) * 32'(input_data);
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [127:0] sb [$];
    logic [15:0]  fw [4][16];
    int cyc = 0;
    int clr_cnt = 0, nv_cnt = 0, nres = 0, lat = 0, clr_cyc = 0;
    logic rv_q = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (clear1) begin
            clr_cnt <= clr_cnt + 1;
            clr_cyc <= cyc;
        end
        if (new_val) nv_cnt <= nv_cnt + 1;
        rv_q <= result_valid;
        if (result_valid && !rv_q) lat <= cyc - clr_cyc;
        if (result_valid && result_ready) begin
            nres <= nres + 1;
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else check("z_result", z, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        @(negedge clock);
        check(tag, {filter_ready, data_ready, result_valid, filters_loaded, busy, r_w1,
                    new_val, clear1, RF_EN, RF1_address, Dot_HOLD}, 17'h00001);
    endtask

    task automatic do_load(input int len, input int gap_at);
        cfg_len = 4'(len);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 4 * (len + 1); k++) begin
            if (k == gap_at) begin
                filter_valid = 1'b0;
                @(negedge clock);
                check("load_gap", {RF_EN, RF1_address}, {4'b0000, 4'(k % (len + 1))});
                tick();
            end
            fw[k / (len + 1)][k % (len + 1)] = 16'(k + 1);
            vector_data  = 16'(k + 1);
            filter_valid = 1'b1;
            @(negedge clock);
            check("load_en_addr", {filter_ready, r_w1, RF_EN, RF1_address},
                  {1'b1, 1'b1, 4'(1 << (k / (len + 1))), 4'(k % (len + 1))});
            tick();
        end
        filter_valid = 1'b0;
        @(negedge clock);
        check("loaded_flag", {filters_loaded, busy}, 2'b10);
        tick();
    endtask

    task automatic do_run(input int len, input int nvec, input int stall_at, input int bp_cycles);
        logic [127:0] e;
        logic [127:0] zs;
        logic [15:0]  x;
        int t;
        cfg_len    = 4'(len);
        cfg_nvec   = 8'(nvec);
        run_start  = 1'b1;
        data_valid = 1'b1;
        tick();
        run_start = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            e = '0;
            t = 0;
            while (!data_ready && t < 20) begin tick(); t++; end
            if (!data_ready) check("run_ready_timeout", 0, 1);
            for (int el = 0; el <= len; el++) begin
                if (el == stall_at) begin
                    data_valid = 1'b0;
                    repeat (3) begin
                        @(negedge clock);
                        check("stall", {RF1_address, new_val, Dot_HOLD}, {4'(el), 1'b0, 1'b1});
                        tick();
                    end
                    data_valid = 1'b1;
                end
                x = 16'($urandom_range(1, 2000));
                input_data = x;
                @(negedge clock);
                check("run_addr", {RF1_address, new_val, Dot_HOLD, data_ready, r_w1, RF_EN},
                      {4'(el), 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111});
                for (int i = 0; i < 4; i++)
                    e[i*32 +: 32] = e[i*32 +: 32] + 32'(fw[i][el]) * 32'(x);
                tick();
            end
            sb.push_back(e);
            if (bp_cycles > 0) begin
                t = 0;
                while (!result_valid && t < 20) begin tick(); t++; end
                if (!result_valid) check("bp_rv_timeout", 0, 1);
                zs = z;
                repeat (bp_cycles) begin
                    @(negedge clock);
                    check("bp_hold", {result_valid, data_ready, z}, {1'b1, 1'b0, zs});
                    tick();
                end
                result_ready = 1'b1;
            end
        end
        data_valid = 1'b0;
        t = 0;
        while (busy && t < 40) begin tick(); t++; end
        check("run_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, n0, r0;
        reset = 1'b1; cfg_len = 4'd0; cfg_nvec = 8'd0; load_start = 1'b0; run_start = 1'b0;
        filter_valid = 1'b0; data_valid = 1'b0; result_ready = 1'b1;
        vector_data = 16'd0; input_data = 16'd0;
        repeat (3) tick();
        check_reset_outs("reset_outs");
        reset = 1'b0;
        tick();

        // partial load of 5 words, then reset
        cfg_len = 4'd3; load_start = 1'b1; tick(); load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vector_data = 16'(k + 1); filter_valid = 1'b1; tick();
        end
        reset = 1'b1; filter_valid = 1'b0;
        tick();
        check_reset_outs("reset_midload");
        reset = 1'b0;
        tick();

        cfg_nvec = 8'd1; run_start = 1'b1; tick(); run_start = 1'b0;
        @(negedge clock);
        check("run_unloaded_ignored", {busy, filters_loaded}, 2'b00);
        tick();

        do_load(3, -1);

        c0 = clr_cnt; n0 = nv_cnt; r0 = nres;
        do_run(3, 2, -1, 0);
        check("clear1_pulses", clr_cnt - c0, 2);
        check("new_val_cycles", nv_cnt - n0, 8);
        check("results", nres - r0, 2);
        check("rv_latency", lat, 6);

        cfg_nvec = 8'd0; run_start = 1'b1; tick(); run_start = 1'b0;
        @(negedge clock);
        check("run_nvec0_ignored", {busy, filters_loaded}, 2'b01);
        tick();

        do_load(5, 3);
        do_run(5, 1, 2, 0);

        result_ready = 1'b0;
        do_run(5, 1, -1, 10);

        cfg_len = 4'd3; cfg_nvec = 8'd2; load_start = 1'b1; run_start = 1'b1;
        tick();
        load_start = 1'b0; run_start = 1'b0;
        @(negedge clock);
        check("both_starts_load", {busy, filter_ready, filters_loaded, clear1}, 4'b1100);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_outs("reset_final");

        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
